count_display_driver: RTL and testbench
=======================================

// Module: count_display_driver
// PURPOSE
//  Downstream consumer of the 4-bit free-running counter value. Converts count (0..15) to two
//  decimal digits and time-multiplexes them onto a 2-digit common-anode 7-segment display.
//  Inserts blanking between digits (ghosting suppression) and snapshots count once per frame (no tearing).
// PARAMETERS
//  SCAN_DIV      16  clock cycles per digit slot (blank + show); must be > BLANK_CYCLES
//  BLANK_CYCLES  2   cycles at slot start with both anodes inactive; must be >= 1
//  LZ_BLANK      1   1 = tens digit stays dark when value < 10
// PORTS
//  clock  in   1  system clock, all state on posedge
//  res    in   1  asynchronous active-low reset
//  count  in   4  unsigned value from the upstream counter, sampled, no handshake
//  an     out  2  digit enables, active-low; an[0]=ones, an[1]=tens
//  seg    out  7  segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  - Clock: one clock `clock`; reset `res` is asynchronous and active-low.
//  - Reset (res=0, async): state=S_BLANK_LO, timer=0, snap=0, an=2'b11, seg=7'h7F.
//  - FSM: S_BLANK_LO -> S_LO -> S_BLANK_HI -> S_HI -> S_BLANK_LO (cyclic).
//    Blank states last BLANK_CYCLES cycles; show states last SCAN_DIV-BLANK_CYCLES cycles.
//    Frame = 2*SCAN_DIV cycles. Timer is internal, counts 0..len-1, clears on each state change.
//  - Snapshot: snap <= count on the edge entering S_BLANK_LO (frame start). Also on first edge
//    after reset release. Count changes mid-frame have no effect until the next frame.
//  - Decimal split from snap: tens = (snap >= 10); ones = tens ? snap-10 : snap (4-bit, no overflow).
//  - Outputs are registered and update on the same edge as state, so they never glitch:
//    blank states: an=2'b11, seg=7'h7F.
//    S_LO: an=2'b10, seg=pattern(ones).
//    S_HI: an=2'b01, seg=pattern(1). If LZ_BLANK and tens==0, an=2'b11 and seg=7'h7F.
//  - Patterns, active-low: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex). Other codes: 7'h7F.
//  - Never both anodes active. A blank of >= BLANK_CYCLES always lies between the two show states.
//  - Wrap: count 15->0 shown as "15" then " 0" at next frame; no special handling.
//  - Reset mid-operation forces reset values immediately; after release, FSM restarts at S_BLANK_LO
//    with timer=0.
// STRUCTURE
//  - Shared package seg7_pkg: state enum, SEG_BLANK=7'h7F, ANODE_OFF=2'b11, 10-entry pattern ROM constant.
//  - One sub-module: seg7_decode (4-bit digit -> 7-bit active-low pattern, combinational).
//  - Top holds FSM, slot timer, snapshot register, decimal split, output registers.
// TESTING (SCAN_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1 unless stated)
//  1. Hold res=0 with count=4'd9 -> an=2'b11, seg=7'h7F. Assert res=0 mid-frame -> same values
//     immediately, without waiting for a clock edge.
//  2. Set count=7, release reset -> ones slot: an=2'b10, seg=7'h78 for 6 cycles. Tens slot: an stays
//     2'b11. Period is 16 cycles.
//  3. Set count=13 -> tens slot: an=2'b01, seg=7'h79. Ones slot: an=2'b10, seg=7'h30.
//     Exactly 2 blank cycles (an=2'b11) between the two slots.
//  4. Change count 3->12 in the middle of S_LO -> the rest of that frame shows "3"; the next frame
//     shows "12" (7'h79 / 7'h24).
//  5. Run LZ_BLANK=0 with count=4 -> tens slot shows "0": an=2'b01, seg=7'h40.
//  6. Sweep count 0..15 and wrap to 0 -> each frame matches the reference table. Assertion:
//     an!=2'b00 on every cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 2-digit multiplexed 7-segment display driver.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 2;

  typedef enum logic [1:0] {
    S_BLANK_LO = 2'd0,
    S_LO       = 2'd1,
    S_BLANK_HI = 2'd2,
    S_HI       = 2'd3
  } state_t;

  localparam logic [SEG_W-1:0] SEG_BLANK  = 7'h7F;
  localparam logic [AN_W-1:0]  ANODE_OFF  = 2'b11;
  localparam logic [AN_W-1:0]  ANODE_ONES = 2'b10;
  localparam logic [AN_W-1:0]  ANODE_TENS = 2'b01;

  localparam logic [0:9][SEG_W-1:0] SEG_ROM = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Non-decimal codes map to a dark digit rather than an arbitrary glyph.
  function automatic logic [SEG_W-1:0] digit_pattern(input logic [DIGIT_W-1:0] d);
    return (d < 4'd10) ? SEG_ROM[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/count_display_driver_if.sv
// Display-side bundle: sampled count value in, anode and segment drives out.
interface count_display_driver_if
  import seg7_pkg::*;
();

  logic [DIGIT_W-1:0] count;
  logic [AN_W-1:0]    an;
  logic [SEG_W-1:0]   seg;

  modport master (output count, input an, input seg);
  modport slave  (input count, output an, output seg);

endinterface

// File: rtl/seg7_decode.sv
// Combinational single-digit to active-low 7-segment pattern decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg_c
);

  assign seg_c = digit_pattern(digit);

endmodule

// File: rtl/count_display_driver.sv
// Multiplexes a 0..15 count onto a 2-digit common-anode display with inter-digit
// blanking; the value is snapshotted once per frame so a digit pair never tears.
module count_display_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic                   clock,
  input  logic                   res,
  count_display_driver_if.slave  disp
);

  localparam int unsigned SHOW_CYCLES = SCAN_DIV - BLANK_CYCLES;
  localparam int unsigned TIMER_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SHOW_LAST  = TIMER_W'(SHOW_CYCLES - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_params
    $error("count_display_driver: need 1 <= BLANK_CYCLES < SCAN_DIV");
  end

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [DIGIT_W-1:0]   snap;
  logic                 fresh;
  logic [AN_W-1:0]      an_q;
  logic [SEG_W-1:0]     seg_q;

  logic                 slot_end_c;
  logic                 load_snap_c;
  logic [DIGIT_W-1:0]   snap_next_c;
  logic                 tens_c;
  logic [DIGIT_W-1:0]   ones_c;
  logic [DIGIT_W-1:0]   digit_c;
  logic [SEG_W-1:0]     pat_c;

  assign slot_end_c = (state == S_BLANK_LO || state == S_BLANK_HI) ? (timer == BLANK_LAST)
                                                                    : (timer == SHOW_LAST);

  // Split from the post-edge snapshot so the first frame after reset is already correct.
  assign load_snap_c = fresh || (state == S_HI && slot_end_c);
  assign snap_next_c = load_snap_c ? disp.count : snap;
  assign tens_c      = (snap_next_c >= 4'd10);
  assign ones_c      = tens_c ? (snap_next_c - 4'd10) : snap_next_c;
  assign digit_c     = (state == S_BLANK_HI) ? DIGIT_W'(tens_c) : ones_c;

  seg7_decode u_decode (
    .digit (digit_c),
    .seg_c (pat_c)
  );

  // Slot FSM; anode/segment registers load on the same edge as the state they belong to.
  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      state <= S_BLANK_LO;
      timer <= '0;
      snap  <= '0;
      fresh <= 1'b1;
      an_q  <= ANODE_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      fresh <= 1'b0;
      snap  <= snap_next_c;
      if (!slot_end_c) begin
        timer <= timer + TIMER_W'(1);
      end else begin
        timer <= '0;
        unique case (state)
          S_BLANK_LO: begin
            state <= S_LO;
            an_q  <= ANODE_ONES;
            seg_q <= pat_c;
          end
          S_LO: begin
            state <= S_BLANK_HI;
            an_q  <= ANODE_OFF;
            seg_q <= SEG_BLANK;
          end
          S_BLANK_HI: begin
            state <= S_HI;
            if (LZ_BLANK && !tens_c) begin
              an_q  <= ANODE_OFF;
              seg_q <= SEG_BLANK;
            end else begin
              an_q  <= ANODE_TENS;
              seg_q <= pat_c;
            end
          end
          S_HI: begin
            state <= S_BLANK_LO;
            an_q  <= ANODE_OFF;
            seg_q <= SEG_BLANK;
          end
          default: begin
            state <= S_BLANK_LO;
            an_q  <= ANODE_OFF;
            seg_q <= SEG_BLANK;
          end
        endcase
      end
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver with SCAN_DIV=8, BLANK_CYCLES=2 (16-cycle frame).
// Phase p = cycles since reset release mod 16: 0,1 blank; 2..7 ones; 8,9 blank; 10..15 tens.
module tb_count_display_driver;

  logic clock = 1'b0;
  logic res   = 1'b0;
  int   k     = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  count_display_driver_if dif  ();
  count_display_driver_if dif2 ();

  count_display_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1'b1)) dut (
    .clock (clock),
    .res   (res),
    .disp  (dif.slave)
  );

  count_display_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1'b0)) dut_nolz (
    .clock (clock),
    .res   (res),
    .disp  (dif2.slave)
  );

  always #5 clock = ~clock;

  // Hand-derived per-value expectations: ones-digit pattern and whether the tens digit is lit.
  logic [6:0] ones_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
  logic       tens_tab [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  always @(negedge clock) begin
    if (res) begin
      n_cmp++;
      if (dif.an === 2'b00 || dif2.an === 2'b00) begin
        n_bad++;
        $display("FAIL anode_overlap t=%0t an=%b an_nolz=%b required never 00", $time, dif.an, dif2.an);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    k++;
  endtask

  task automatic advance_to(input int p);
    tick();
    for (int i = 0; i < 16 && (k % 16) != p; i++) tick();
  endtask

  task automatic test_reset();
    dif.count  = 4'd9;
    dif2.count = 4'd4;
    res = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (dif.an !== 2'b11) begin n_bad++; $display("FAIL reset_an got=%b exp=11", dif.an); end
    n_cmp++;
    if (dif.seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got=%h exp=7f", dif.seg); end
  endtask

  task automatic test_ones_only();
    dif.count = 4'd7;
    res = 1'b1;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      logic [1:0] ea;
      logic [6:0] es;
      tick();
      if ((k % 16) >= 2 && (k % 16) <= 7) begin ea = 2'b10; es = 7'h78; end
      else begin ea = 2'b11; es = 7'h7F; end
      n_cmp++;
      if (dif.an !== ea || dif.seg !== es) begin
        n_bad++;
        $display("FAIL ones_only p=%0d got an=%b seg=%h exp an=%b seg=%h", k % 16, dif.an, dif.seg, ea, es);
      end
    end
  endtask

  task automatic test_two_digits();
    int blank_run = 0;
    int blank_gap = -1;
    dif.count = 4'd13;
    advance_to(0);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] ea;
      logic [6:0] es;
      int p;
      tick();
      p = k % 16;
      if (p >= 2 && p <= 7)        begin ea = 2'b10; es = 7'h30; end
      else if (p >= 10)            begin ea = 2'b01; es = 7'h79; end
      else                         begin ea = 2'b11; es = 7'h7F; end
      n_cmp++;
      if (dif.an !== ea || dif.seg !== es) begin
        n_bad++;
        $display("FAIL two_digits p=%0d got an=%b seg=%h exp an=%b seg=%h", p, dif.an, dif.seg, ea, es);
      end
      if (p >= 8 && dif.an === 2'b11) blank_run++;
      if (p >= 8 && dif.an === 2'b01 && blank_gap < 0) blank_gap = blank_run;
    end
    n_cmp++;
    if (blank_gap !== 2) begin n_bad++; $display("FAIL blank_gap got=%0d exp=2", blank_gap); end
  endtask

  task automatic test_mid_frame();
    dif.count = 4'd3;
    advance_to(0);
    advance_to(4);
    dif.count = 4'd12;
    for (int i = 0; i < 28; i++) begin
      logic [1:0] ea;
      logic [6:0] es;
      int p;
      bit second;
      tick();
      p = k % 16;
      second = (i >= 12);
      if (p >= 2 && p <= 7)               begin ea = 2'b10; es = second ? 7'h24 : 7'h30; end
      else if (p >= 10 && second)         begin ea = 2'b01; es = 7'h79; end
      else                                begin ea = 2'b11; es = 7'h7F; end
      n_cmp++;
      if (dif.an !== ea || dif.seg !== es) begin
        n_bad++;
        $display("FAIL mid_frame i=%0d p=%0d got an=%b seg=%h exp an=%b seg=%h", i, p, dif.an, dif.seg, ea, es);
      end
    end
  endtask

  task automatic test_no_lz();
    advance_to(2);
    n_cmp++;
    if (dif2.an !== 2'b10 || dif2.seg !== 7'h19) begin
      n_bad++;
      $display("FAIL nolz_ones got an=%b seg=%h exp an=10 seg=19", dif2.an, dif2.seg);
    end
    advance_to(10);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (dif2.an !== 2'b01 || dif2.seg !== 7'h40) begin
        n_bad++;
        $display("FAIL nolz_tens p=%0d got an=%b seg=%h exp an=01 seg=40", k % 16, dif2.an, dif2.seg);
      end
      tick();
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v <= 16; v++) begin
      int val;
      val = v % 16;
      dif.count = 4'(val);
      advance_to(0);
      for (int i = 0; i < 16; i++) begin
        logic [1:0] ea;
        logic [6:0] es;
        int p;
        tick();
        p = k % 16;
        if (p >= 2 && p <= 7)              begin ea = 2'b10; es = ones_tab[val]; end
        else if (p >= 10 && tens_tab[val]) begin ea = 2'b01; es = 7'h79; end
        else                               begin ea = 2'b11; es = 7'h7F; end
        n_cmp++;
        if (dif.an !== ea || dif.seg !== es) begin
          n_bad++;
          $display("FAIL sweep v=%0d p=%0d got an=%b seg=%h exp an=%b seg=%h", val, p, dif.an, dif.seg, ea, es);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    dif.count = 4'd8;
    advance_to(0);
    advance_to(4);
    #2;
    res = 1'b0;
    #1;
    n_cmp++;
    if (dif.an !== 2'b11 || dif.seg !== 7'h7F) begin
      n_bad++;
      $display("FAIL async_reset got an=%b seg=%h exp an=11 seg=7f", dif.an, dif.seg);
    end
    n_cmp++;
    if (dif2.an !== 2'b11 || dif2.seg !== 7'h7F) begin
      n_bad++;
      $display("FAIL async_reset_nolz got an=%b seg=%h exp an=11 seg=7f", dif2.an, dif2.seg);
    end
    repeat (2) tick();
    dif.count = 4'd5;
    res = 1'b1;
    k = 0;
    tick();
    n_cmp++;
    if (dif.an !== 2'b11 || dif.seg !== 7'h7F) begin
      n_bad++;
      $display("FAIL restart_blank got an=%b seg=%h exp an=11 seg=7f", dif.an, dif.seg);
    end
    tick();
    n_cmp++;
    if (dif.an !== 2'b10 || dif.seg !== 7'h12) begin
      n_bad++;
      $display("FAIL restart_ones got an=%b seg=%h exp an=10 seg=12", dif.an, dif.seg);
    end
  endtask

  initial begin
    test_reset();
    test_ones_only();
    test_two_digits();
    test_mid_frame();
    test_no_lz();
    test_sweep();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
